// File: rtl/spike_pkg.sv
// Shared constants and FSM state type for the spike rate decoder slice.
package spike_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int ISI_W_DEF   = 12;
  localparam int WIN_LEN_DEF = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike counter with valid/ready result port and sticky overrun flag.
// Optional last-ISI measurement is built when SPIKE_DECODER_ISI_EN is defined.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ISI_W   = ISI_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [ISI_W-1:0] out_isi,
  output logic             overrun,
  output logic             busy
);

  localparam int                WCNT_W = $clog2(WIN_LEN);
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(WIN_LEN - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               overrun_q, overrun_d;

  logic               run_active;
  logic               win_close;
  logic               drain;
  logic [CNT_W-1:0]   scnt;
  logic [CNT_W-1:0]   cand;

  // Dropping en in RUN discards this cycle's sample along with the partial window.
  assign run_active = (state_q == RUN) && en;
  assign win_close  = run_active && (wcnt_q == W_LAST);
  assign drain      = out_valid_q && out_ready;
  assign cand       = (spike && (scnt != '1)) ? scnt + CNT_W'(1) : scnt;

  sat_counter #(.W(CNT_W)) u_scnt (
    .clk (clk),
    .rst (rst),
    .clr (!run_active || win_close),
    .inc (spike),
    .q   (scnt)
  );

  always_comb begin
    state_d     = en ? RUN : IDLE;
    wcnt_d      = (run_active && !win_close) ? wcnt_q + WCNT_W'(1) : '0;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    overrun_d   = overrun_q;
    if (drain) out_valid_d = 1'b0;
    if (win_close) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_count_d = cand;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == RUN);

`ifdef SPIKE_DECODER_ISI_EN
  logic             armed_q, armed_d;
  logic [ISI_W-1:0] out_isi_q, out_isi_d;
  logic [ISI_W-1:0] isi_cnt;

  // isi_cnt restarts from 0 on the cycle after a spike, so the interval is isi_cnt + 1.
  sat_counter #(.W(ISI_W)) u_isi (
    .clk (clk),
    .rst (rst),
    .clr (!run_active || spike),
    .inc (1'b1),
    .q   (isi_cnt)
  );

  always_comb begin
    armed_d   = run_active ? armed_q : 1'b0;
    out_isi_d = out_isi_q;
    if (run_active && spike) begin
      armed_d = 1'b1;
      if (armed_q) out_isi_d = (isi_cnt == '1) ? isi_cnt : isi_cnt + ISI_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      out_isi_q <= '0;
    end else begin
      armed_q   <= armed_d;
      out_isi_q <= out_isi_d;
    end
  end

  assign out_isi = out_isi_q;
`else
  assign out_isi = '0;
`endif

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike interface: consumes a single-bit spike train and decodes it back into a magnitude.
- Counts spikes over a fixed sampling window and presents each window's count on a valid/ready output port.
- Optionally measures the most recent inter-spike interval (ISI).
- Sits downstream of the integrate-and-fire neuron array, ahead of readout/host logic.

Parameters:
- WIN_LEN, 256, window length in clock cycles; legal range 2..65536.
- CNT_W, 8, width of the spike count and of out_count.
- ISI_W, 12, width of the ISI counter and of out_isi.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  decode enable.
- spike  in  1  spike from the neuron; synchronous to clk; one spike per high cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CNT_W  spikes in the completed window, saturating.
- out_isi  out  ISI_W  last complete ISI in cycles, saturating.
- overrun  out  1  sticky; a window result was dropped.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, rst=1) forces:
  - FSM to IDLE.
  - Window counter, spike counter, ISI counter, ISI-armed flag, out_valid, out_count, out_isi and overrun all to 0.
  - Reset mid-window discards the partial window with no output.
- FSM has two states:
  - IDLE: counters held at 0; IDLE to RUN on the first edge with en=1.
  - RUN: counters active; RUN to IDLE on any edge with en=0.
  - On en=0, the partial window is discarded and wcnt, scnt, ISI counter and ISI-armed flag are cleared. A pending result (out_valid=1) stays until handshaked.
- Window timing:
  - wcnt counts 0..WIN_LEN-1 in RUN, then wraps to 0.
  - The cycle with wcnt==WIN_LEN-1 is the closing cycle; a spike in that cycle belongs to the closing window.
  - The first window starts on the first RUN cycle, so exactly WIN_LEN spike samples fall in every window.
- Spike counting: scnt increments on each cycle with spike=1 and saturates at 2^CNT_W-1. It clears to 0 at the closing edge; a spike in the next cycle counts as 1 in the new window.
- Result transfer at the closing edge: the candidate is sat(scnt+spike).
  - Output buffer free (out_valid=0) or draining this cycle (out_valid & out_ready): load out_count, set out_valid=1.
  - Otherwise: drop the candidate, keep the old out_count, set overrun=1.
  - Latency: out_valid rises the cycle after the closing cycle.
- Handshake:
  - The transfer occurs on an edge with out_valid & out_ready.
  - out_valid clears unless a new result loads on the same edge.
  - out_count is stable while out_valid=1 and !out_ready.
  - out_ready while out_valid=0 has no effect.
- overrun: sticky, cleared only by rst.
- busy = (state==RUN).

Optional Feature:
- Macro: SPIKE_DECODER_ISI_EN.
- Defined:
  - ISI counter runs in RUN, saturating at 2^ISI_W-1.
  - On a spike with the armed flag set, out_isi loads the cycles since the previous spike (adjacent-cycle spikes give 1) and the counter restarts.
  - The first spike after entering RUN only arms the flag.
  - out_isi updates independently of the handshake; it is not held by out_valid.
- Undefined: no ISI logic; out_isi tied to 0; port list unchanged.

Decomposition:
- Shared package spike_pkg holds:
  - Default constants CNT_W_DEF=8, ISI_W_DEF=12, WIN_LEN_DEF=256.
  - The FSM state typedef {IDLE, RUN}.
- One natural sub-module, sat_counter (parameterised width, inc, clear, saturate). It is instantiated for scnt and for the ISI counter.

Test Plan:
- Reset: rst pulse asynchronous to clk -> all outputs 0 immediately; partial window discarded, no out_valid afterwards.
- Rate decode: WIN_LEN=256, spike every 8th cycle, out_ready=1 -> out_count=32 every 256 cycles, out_valid one cycle per window.
- Saturation/boundary: spike every cycle, CNT_W=8 -> out_count=255. Separately, a single spike in the closing cycle only -> out_count=1, next window=0.
- Backpressure: out_ready=0 across two window closes -> first count held stable, second dropped, overrun=1. With out_ready=1 asserted on the closing edge instead -> new count loads, no overrun.
- Enable: en drops mid-window after 5 spikes, then re-raised -> busy=0, no result for the partial window, next full window counts from 0.
- ISI (SPIKE_DECODER_ISI_EN): spikes at cycles 10, 17, 5000 with ISI_W=12 -> out_isi=0 after the first spike, 7 after the second, 4095 (saturated) after the third.
